// File: rtl/aes_key_schedule_seq_if.sv
// Bus bundle for the AES-128 key-schedule controller: start/key request,
// status flags and the registered round-key read port.
interface aes_key_schedule_seq_if;
  // start is a single-cycle request accepted only while busy=0; busy covers the
  // whole expansion, done pulses once when round key 10 lands, and key_valid
  // qualifies every rd_key read (rd_key appears one clock after rd_addr/rd_rev).
  logic         start;
  logic [0:127] key_in;
  logic         busy;
  logic         done;
  logic         key_valid;
  logic [3:0]   rd_addr;
  logic         rd_rev;
  logic [0:127] rd_key;

  modport master (
    output start, key_in, rd_addr, rd_rev,
    input  busy, done, key_valid, rd_key
  );

  modport slave (
    input  start, key_in, rd_addr, rd_rev,
    output busy, done, key_valid, rd_key
  );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 key schedule: one key_gen round per clock, 11 round keys
// held in a register file and read back by index in forward or reverse order.

module key_gen (
  input  logic [0:127] temp_key,
  input  logic [0:31]  rcon,
  output logic [0:127] ko
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse (x^254, so 0 maps to 0) plus the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  logic [0:31] w0, w1, w2, w3, rw, sw, n0, n1, n2, n3;

  always_comb begin
    w0 = temp_key[0:31];
    w1 = temp_key[32:63];
    w2 = temp_key[64:95];
    w3 = temp_key[96:127];
    rw = {w3[8:31], w3[0:7]};
    sw = {sbox(rw[0:7]), sbox(rw[8:15]), sbox(rw[16:23]), sbox(rw[24:31])};
    n0 = w0 ^ sw ^ rcon;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    ko = {n0, n1, n2, n3};
  end
endmodule

module aes_key_schedule_seq #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_key_schedule_seq_if.slave bus,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [3:0]   round;
  logic [0:31]  rcon;
  logic [0:127] cur;
  logic [0:127] ko;
  logic [0:127] store [0:NR];
  logic [0:127] rd_key_q;
  logic         done_q;
  logic         rd_ok;
  logic [3:0]   rd_idx;
  logic         accept;
  logic [7:0]   rcon_next;

  key_gen u_key_gen (
    .temp_key (cur),
    .rcon     (rcon),
    .ko       (ko)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, READY: if (bus.start) state_nxt = EXPAND;
      EXPAND:      if (round == 4'(NR)) state_nxt = READY;
      default:     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state == EXPAND);
    bus.key_valid = (state == READY);
    bus.done      = done_q;
    bus.rd_key    = rd_key_q;
    dbg_state     = state;
  end

  // Out-of-range indices read as zero in both directions; no wrap-around.
  always_comb begin
    accept    = bus.start && (state == IDLE || state == READY);
    rd_ok     = (bus.rd_addr <= 4'(NR));
    rd_idx    = bus.rd_rev ? (4'(NR) - bus.rd_addr) : bus.rd_addr;
    rcon_next = {rcon[1:7], 1'b0} ^ (rcon[0] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      round    <= 4'd0;
      rcon     <= 32'h0;
      cur      <= 128'h0;
      done_q   <= 1'b0;
      rd_key_q <= 128'h0;
      for (int i = 0; i <= NR; i++) store[i] <= 128'h0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        store[0] <= bus.key_in;
        cur      <= bus.key_in;
        rcon     <= 32'h01000000;
        round    <= 4'd1;
      end else if (state == EXPAND) begin
        store[round] <= ko;
        cur          <= ko;
        rcon         <= {rcon_next, 24'h0};
        round        <= round + 4'd1;
        if (round == 4'(NR)) done_q <= 1'b1;
      end
      rd_key_q <= rd_ok ? store[rd_idx] : 128'h0;
    end
  end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using FIPS-197 and all-zero key vectors.
module tb_aes_key_schedule_seq;
  localparam logic [1:0]   ST_IDLE   = 2'd0;
  localparam logic [1:0]   ST_READY  = 2'd2;
  localparam logic [127:0] KEY_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_ZERO  = 128'h0;
  localparam logic [127:0] ZERO_R1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_total;
  int         n_pass;

  aes_key_schedule_seq_if bus ();

  aes_key_schedule_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic read_check(input string tag, input logic [3:0] addr, input logic rev,
                            input logic [127:0] exp);
    bus.rd_addr = addr;
    bus.rd_rev  = rev;
    tick;
    check(tag, bus.rd_key, exp);
  endtask

  // Pulses start for the E0 edge, scrambles key_in afterwards, then follows the
  // ten expansion cycles; inject>0 fires a second start with the zero key in that cycle.
  task automatic expand(input string tag, input logic [127:0] key, input int inject);
    bus.start  = 1'b1;
    bus.key_in = key;
    tick;
    bus.start  = 1'b0;
    bus.key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    for (int i = 1; i <= 10; i++) begin
      check({tag, " busy"}, 128'(bus.busy), 128'd1);
      check({tag, " done_low"}, 128'(bus.done), 128'd0);
      check({tag, " kv_low"}, 128'(bus.key_valid), 128'd0);
      if (i == inject) begin
        bus.start  = 1'b1;
        bus.key_in = KEY_ZERO;
      end
      tick;
      bus.start = 1'b0;
    end
    check({tag, " done_pulse"}, 128'(bus.done), 128'd1);
    check({tag, " busy_end"}, 128'(bus.busy), 128'd0);
    check({tag, " kv_end"}, 128'(bus.key_valid), 128'd1);
    check({tag, " state_ready"}, 128'(dbg_state), 128'(ST_READY));
    tick;
    check({tag, " done_clear"}, 128'(bus.done), 128'd0);
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.key_in  = KEY_ZERO;
    bus.rd_addr = 4'd0;
    bus.rd_rev  = 1'b0;
    tick;
    tick;
    check("rst_state", 128'(dbg_state), 128'(ST_IDLE));
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_kv", 128'(bus.key_valid), 128'd0);
    check("rst_rdkey", bus.rd_key, 128'h0);
    rst = 1'b0;
    tick;

    expand("fips", KEY_FIPS, 0);
    read_check("fips_r1", 4'd1, 1'b0, FIPS_R1);
    read_check("fips_r10", 4'd10, 1'b0, FIPS_R10);
    read_check("fips_r0", 4'd0, 1'b0, KEY_FIPS);
    read_check("rev_a0", 4'd0, 1'b1, FIPS_R10);
    read_check("rev_a10", 4'd10, 1'b1, KEY_FIPS);
    read_check("rev_a9", 4'd9, 1'b1, FIPS_R1);
    read_check("fwd_a11", 4'd11, 1'b0, 128'h0);
    read_check("fwd_a15", 4'd15, 1'b0, 128'h0);
    read_check("rev_a11", 4'd11, 1'b1, 128'h0);
    read_check("rev_a15", 4'd15, 1'b1, 128'h0);

    // Restart from READY: key_valid drops at the start edge.
    expand("zero", KEY_ZERO, 0);
    read_check("zero_r0", 4'd0, 1'b0, KEY_ZERO);
    read_check("zero_r1", 4'd1, 1'b0, ZERO_R1);
    read_check("zero_r10", 4'd10, 1'b0, ZERO_R10);

    // A start in cycle 5 of the expansion must be ignored.
    expand("ignore", KEY_FIPS, 5);
    read_check("ignore_r0", 4'd0, 1'b0, KEY_FIPS);
    read_check("ignore_r1", 4'd1, 1'b0, FIPS_R1);
    read_check("ignore_r10", 4'd10, 1'b0, FIPS_R10);

    // Reset in cycle 4 of EXPAND discards everything.
    bus.start  = 1'b1;
    bus.key_in = KEY_ZERO;
    tick;
    bus.start = 1'b0;
    check("pre_rst_busy", 128'(bus.busy), 128'd1);
    tick;
    tick;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("mid_rst_state", 128'(dbg_state), 128'(ST_IDLE));
    check("mid_rst_busy", 128'(bus.busy), 128'd0);
    check("mid_rst_kv", 128'(bus.key_valid), 128'd0);
    check("mid_rst_done", 128'(bus.done), 128'd0);
    read_check("mid_rst_r0", 4'd0, 1'b0, 128'h0);
    read_check("mid_rst_r1", 4'd1, 1'b0, 128'h0);
    read_check("mid_rst_r10", 4'd10, 1'b0, 128'h0);
    check("mid_rst_idle_hold", 128'(dbg_state), 128'(ST_IDLE));

    // rst and start together: reset wins.
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.key_in = KEY_FIPS;
    tick;
    rst       = 1'b0;
    bus.start = 1'b0;
    check("rst_start_state", 128'(dbg_state), 128'(ST_IDLE));
    check("rst_start_busy", 128'(bus.busy), 128'd0);
    tick;
    check("rst_start_hold", 128'(dbg_state), 128'(ST_IDLE));
    read_check("rst_start_r0", 4'd0, 1'b0, 128'h0);

    expand("clean", KEY_FIPS, 0);
    read_check("clean_r1", 4'd1, 1'b0, FIPS_R1);
    read_check("clean_r10", 4'd10, 1'b0, FIPS_R10);
    read_check("clean_rev0", 4'd0, 1'b1, FIPS_R10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/aes_key_schedule_seq.md
Name: aes_key_schedule_seq

Overview:
Sequential AES-128 key-schedule controller. It wraps one instance of the combinational single-round expander key_gen (temp_key[0:127], rcon[0:31] in; ko[0:127] out). It iterates key_gen once per clock, generates the rcon sequence, and stores all 11 round keys in a register file. The decryption datapath downstream reads round keys by index, in forward or reverse order.

Parameters:
NR, 10, number of expansion rounds; only 10 (AES-128) is supported; the store holds NR+1 keys.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
start  input  1  begin expansion of key_in; sampled only in IDLE or READY
key_in  input  [0:127]  cipher key, bit 0 = MSB of byte 0, column-wise byte order as used by key_gen
busy  output  1  high while expansion is in progress
done  output  1  one-cycle pulse when round key 10 has been written
key_valid  output  1  high when all 11 stored keys belong to the latest start
rd_addr  input  [3:0]  round-key index 0..10
rd_rev  input  1  1: effective index = 10 - rd_addr (decryption order); 0: index = rd_addr
rd_key  output  [0:127]  registered read data

Behaviour:
- States: IDLE, EXPAND, READY.
- Reset (rst=1 at a clk edge):
  - state to IDLE.
  - busy, done, key_valid, rd_key all 0.
  - Round counter 0, rcon register 0, all 11 store entries 0.
  - Reset has priority over every other input, including in mid-EXPAND; the partial expansion is discarded.
- IDLE or READY, start=1 at edge E0:
  - store[0] <= key_in; cur <= key_in.
  - rcon <= 32'h01000000; round <= 1.
  - state <= EXPAND; busy <= 1; key_valid <= 0; done <= 0.
  - key_in is sampled only at E0 and may change afterwards.
- EXPAND, each edge Ek (k = 1..10):
  - store[k] <= ko; cur <= ko, where key_gen is driven by temp_key=cur and rcon=rcon register.
  - rcon byte 0 <= xtime(byte 0): shift left 1; if the old MSB was 1, xor 8'h1B. rcon bytes 1..3 stay 0.
  - rcon byte-0 sequence over k = 1..10: 01 02 04 08 10 20 40 80 1B 36.
  - round <= round + 1.
- At E10:
  - state <= READY; busy <= 0; done <= 1 for exactly one cycle; key_valid <= 1.
- Latency: done is high in the cycle following E10, i.e. 10 clocks after the start edge. busy is high for exactly 10 cycles.
- start during EXPAND is ignored; no restart and no queueing.
- start in READY restarts: key_valid drops at that edge and store[0] is overwritten immediately.
- Read path (every edge, all states):
  - rd_key <= store[idx], where idx is the effective index from rd_addr/rd_rev.
  - One-cycle latency.
  - Effective idx > 10 (rd_rev=0 with rd_addr 11..15) returns 128'h0.
  - rd_rev=1 with rd_addr > 10 also returns 0; no wrap-around.
- Reads during EXPAND return current store contents, which may be stale or partial. Consumers must qualify reads with key_valid.
- rst and start both high at the same edge: reset wins; state stays IDLE.
- done and start both high at the same edge (start in READY the cycle after E10): restart is taken and done still deasserts at that edge.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start 1 cycle -> busy high 10 cycles; done pulses 10 clocks after start; key_valid=1; rd_addr=1 -> a0fafe1788542cb123a339392a6c7605; rd_addr=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6; rd_addr=0 -> original key.
- After expansion, rd_rev=1, rd_addr=0 -> d014f9a8...0ca6 one cycle later; rd_rev=1, rd_addr=10 -> 2b7e1516...4f3c; rd_addr=11..15 with either rd_rev value -> 0.
- All-zero key -> round 1 key 62636363626363636263636362636363; round 10 key b4ef5bcb3e92e21123e951cf6f8f188e.
- Pulse start again at cycle 5 of an expansion with a different key_in -> ignored; final keys match the first key; done timing unchanged.
- Assert rst at cycle 4 of EXPAND -> next cycle state IDLE, busy=0, key_valid=0, all rd_key reads 0; a new start then expands cleanly.
- From READY, start with a new key -> key_valid falls at the start edge; after 10 clocks store holds the new schedule; rst and start high together -> remains IDLE, busy=0.
